// File: rtl/alu_arb.sv
// Two-requester arbiter in front of a shared combinational ALU with a LAT-cycle settle time.
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority; otherwise contention is round-robin.
module alu_arb #(
    parameter int LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [7:0]  aluc_in,
    input  logic [63:0] a_in,
    input  logic [63:0] b_in,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_s,
    input  logic        alu_z,
    output logic [31:0] res,
    output logic        res_z,
    output logic        busy
);

    typedef enum logic {IDLE, EXEC} state_t;

    localparam logic [2:0] LAT_C = 3'(LAT);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_aluc_q, alu_aluc_d;
    logic [31:0] res_q, res_d;
    logic        res_z_q, res_z_d;
    logic        last_w_q, last_w_d;
    logic        win;

    // last_w doubles as the owner of the operation in flight, so done is steered from it.
    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        win = ~req[0];
`else
        win = (req == 2'b11) ? ~last_w_q : req[1];
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = 2'b00;
        done_d     = 2'b00;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_aluc_d = alu_aluc_q;
        res_d      = res_q;
        res_z_d    = res_z_q;
        last_w_d   = last_w_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d    = EXEC;
                    cnt_d      = LAT_C;
                    gnt_d      = win ? 2'b10 : 2'b01;
                    alu_a_d    = win ? a_in[63:32] : a_in[31:0];
                    alu_b_d    = win ? b_in[63:32] : b_in[31:0];
                    alu_aluc_d = win ? aluc_in[7:4] : aluc_in[3:0];
                    last_w_d   = win;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                    res_d   = alu_s;
                    res_z_d = alu_z;
                    done_d  = last_w_q ? 2'b10 : 2'b01;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            alu_a_q    <= 32'd0;
            alu_b_q    <= 32'd0;
            alu_aluc_q <= 4'd0;
            res_q      <= 32'd0;
            res_z_q    <= 1'b0;
            last_w_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_aluc_q <= alu_aluc_d;
            res_q      <= res_d;
            res_z_q    <= res_z_d;
            last_w_q   <= last_w_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_aluc = alu_aluc_q;
    assign res      = res_q;
    assign res_z    = res_z_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: three instances (LAT 1,2,3) share stimulus; each is checked against a
// transaction-level model that predicts grant, completion time and result per operation.
module tb_alu_arb;

    localparam int NI = 3;

    logic        clock;
    logic        reset;
    logic [1:0]  req;
    logic [7:0]  aluc_in;
    logic [63:0] a_in;
    logic [63:0] b_in;

    logic [1:0]  gnt_w      [NI];
    logic [1:0]  done_w     [NI];
    logic [31:0] alu_a_w    [NI];
    logic [31:0] alu_b_w    [NI];
    logic [3:0]  alu_aluc_w [NI];
    logic [31:0] alu_s_w    [NI];
    logic        alu_z_w    [NI];
    logic [31:0] res_w      [NI];
    logic        res_z_w    [NI];
    logic        busy_w     [NI];

    int n_cmp;
    int n_bad;
    int cyc;

    // Shared ALU behaviour: 0000 add, 0100 sub, 0101 or, 0110 xor, 0111 and, others add.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0100: return a - b;
            4'b0101: return a | b;
            4'b0110: return a ^ b;
            4'b0111: return a & b;
            default: return a + b;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        alu_arb #(.LAT(g + 1)) u_dut (
            .clock    (clock),
            .reset    (reset),
            .req      (req),
            .aluc_in  (aluc_in),
            .a_in     (a_in),
            .b_in     (b_in),
            .gnt      (gnt_w[g]),
            .done     (done_w[g]),
            .alu_a    (alu_a_w[g]),
            .alu_b    (alu_b_w[g]),
            .alu_aluc (alu_aluc_w[g]),
            .alu_s    (alu_s_w[g]),
            .alu_z    (alu_z_w[g]),
            .res      (res_w[g]),
            .res_z    (res_z_w[g]),
            .busy     (busy_w[g])
        );
        assign alu_s_w[g] = alu_f(alu_aluc_w[g], alu_a_w[g], alu_b_w[g]);
        assign alu_z_w[g] = (alu_s_w[g] == 32'd0);
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state: one in-flight operation per instance, finishing at an absolute edge.
    bit          m_busy    [NI];
    int          m_last    [NI];
    int          m_owner   [NI];
    int          m_done_at [NI];
    logic [31:0] m_pend_s  [NI];
    logic [1:0]  e_gnt     [NI];
    logic [1:0]  e_done    [NI];
    logic [31:0] e_a       [NI];
    logic [31:0] e_b       [NI];
    logic [3:0]  e_op      [NI];
    logic [31:0] e_res     [NI];
    logic        e_z       [NI];

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_busy[k] = 0; m_last[k] = 1; m_owner[k] = 0; m_done_at[k] = 0; m_pend_s[k] = '0;
            e_gnt[k] = '0; e_done[k] = '0; e_a[k] = '0; e_b[k] = '0; e_op[k] = '0;
            e_res[k] = '0; e_z[k] = 1'b0;
        end
    endtask

    function automatic int pick(input logic [1:0] r, input int last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (last == 0) ? 1 : 0;
`endif
    endfunction

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            e_gnt[k]  = 2'b00;
            e_done[k] = 2'b00;
            if (m_busy[k]) begin
                if (cyc == m_done_at[k]) begin
                    e_done[k] = 2'(1 << m_owner[k]);
                    e_res[k]  = m_pend_s[k];
                    e_z[k]    = (m_pend_s[k] == 32'd0);
                    m_busy[k] = 0;
                end
            end else if (req != 2'b00) begin
                int w;
                w = pick(req, m_last[k]);
                m_owner[k]   = w;
                m_last[k]    = w;
                m_busy[k]    = 1;
                m_done_at[k] = cyc + k + 1;
                e_gnt[k]     = 2'(1 << w);
                e_a[k]       = a_in[32*w +: 32];
                e_b[k]       = b_in[32*w +: 32];
                e_op[k]      = aluc_in[4*w +: 4];
                m_pend_s[k]  = alu_f(e_op[k], e_a[k], e_b[k]);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("u%0d.gnt", k),   32'(gnt_w[k]),      32'(e_gnt[k]));
            chk($sformatf("u%0d.done", k),  32'(done_w[k]),     32'(e_done[k]));
            chk($sformatf("u%0d.busy", k),  32'(busy_w[k]),     32'(m_busy[k]));
            chk($sformatf("u%0d.alu_a", k), alu_a_w[k],         e_a[k]);
            chk($sformatf("u%0d.alu_b", k), alu_b_w[k],         e_b[k]);
            chk($sformatf("u%0d.aluc", k),  32'(alu_aluc_w[k]), 32'(e_op[k]));
            chk($sformatf("u%0d.res", k),   res_w[k],           e_res[k]);
            chk($sformatf("u%0d.res_z", k), 32'(res_z_w[k]),    32'(e_z[k]));
        end
    endtask

    task automatic step();
        @(posedge clock);
        cyc++;
        if (reset) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        req = 2'b00;
        repeat (n) step();
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        step();
        #2 reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        reset = 1'b1; req = '0; aluc_in = '0; a_in = '0; b_in = '0;
        model_reset();
        #1 check_all();
        step();
        #2 reset = 1'b0;

        // requester 0 add 5+7 on LAT=1
        req = 2'b01; aluc_in = 8'h00; a_in = {32'd0, 32'd5}; b_in = {32'd0, 32'd7};
        step();
        chk("r029.gnt", 32'(gnt_w[0]), 32'h1);
        req = 2'b00;
        step();
        chk("r029.done", 32'(done_w[0]), 32'h1);
        chk("r029.res", res_w[0], 32'd12);
        chk("r029.res_z", 32'(res_z_w[0]), 32'h0);
        idle(4);

        // requester 1 sub 9-9 gives zero flag
        req = 2'b10; aluc_in = 8'h40; a_in = {32'd9, 32'd0}; b_in = {32'd9, 32'd0};
        step();
        req = 2'b00;
        step();
        chk("r030.done", 32'(done_w[0]), 32'h2);
        chk("r030.res", res_w[0], 32'd0);
        chk("r030.res_z", 32'(res_z_w[0]), 32'h1);
        idle(4);

        // both requesting constantly
        req = 2'b11; aluc_in = 8'h00; a_in = {32'd3, 32'd1}; b_in = {32'd4, 32'd2};
        for (int i = 0; i < 8; i++) begin
            step();
            if (i % 2 == 0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                chk($sformatf("r031.gnt%0d", i / 2), 32'(gnt_w[0]), 32'h1);
`else
                chk($sformatf("r031.gnt%0d", i / 2), 32'(gnt_w[0]), (i % 4 == 0) ? 32'h1 : 32'h2);
`endif
            end
        end
        idle(5);

        // LAT=3 or of 0x00F0 and 0x0F00
        req = 2'b01; aluc_in = 8'h05; a_in = {32'd0, 32'h00F0}; b_in = {32'd0, 32'h0F00};
        step();
        chk("r032.gnt", 32'(gnt_w[2]), 32'h1);
        req = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("r032.busy%0d", i), 32'(busy_w[2]), 32'h1);
            step();
            chk($sformatf("r032.done%0d", i), 32'(done_w[2]), (i == 3) ? 32'h1 : 32'h0);
        end
        chk("r032.res", res_w[2], 32'h0FF0);
        idle(3);

        // operand change after grant must not disturb LAT=2 operation
        req = 2'b01; aluc_in = 8'h00; a_in = {32'd0, 32'd5}; b_in = {32'd0, 32'd1};
        step();
        req = 2'b00; a_in = {32'd0, 32'd100};
        step();
        step();
        chk("r034.done", 32'(done_w[1]), 32'h1);
        chk("r034.res", res_w[1], 32'd6);
        idle(4);

        // reset one cycle after a LAT=3 grant
        req = 2'b01; aluc_in = 8'h00; a_in = {32'd0, 32'd20}; b_in = {32'd0, 32'd22};
        step();
        req = 2'b00;
        step();
        async_reset_pulse();
        chk("r033.busy", 32'(busy_w[2]), 32'h0);
        chk("r033.res", res_w[2], 32'h0);
        idle(4);
        req = 2'b01;
        step();
        chk("r033.regrant", 32'(gnt_w[2]), 32'h1);
        idle(4);

        // randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 600; i++) begin
            req     = 2'($urandom_range(3));
            aluc_in = 8'($urandom);
            a_in    = {$urandom, $urandom};
            b_in    = ($urandom_range(7) == 0) ? a_in : {$urandom, $urandom};
            if ($urandom_range(79) == 0) async_reset_pulse();
            else step();
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter LAT, default 1, ALU settle time in clock cycles between operand issue and result capture; legal 1..7.
REQ-002 clock  input  1  single clock, all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  2  level request per requester; bit i = requester i.
REQ-005 aluc_in  input  8  op codes; [3:0] requester 0, [7:4] requester 1; same 4-bit encoding as the shared ALU.
REQ-006 a_in  input  64  operand a; [31:0] requester 0, [63:32] requester 1.
REQ-007 b_in  input  64  operand b; same packing as a_in.
REQ-008 gnt  output  2  one-hot one-cycle grant pulse, registered.
REQ-009 done  output  2  one-hot one-cycle result-valid pulse, registered.
REQ-010 alu_a, alu_b  output  32 each  registered operands driven to the shared combinational ALU.
REQ-011 alu_aluc  output  4  registered op code driven to the shared ALU.
REQ-012 alu_s  input  32  ALU result; alu_z  input  1  ALU zero flag.
REQ-013 res  output  32  captured result; res_z  output  1  captured zero flag; both hold until next capture.
REQ-014 busy  output  1  high when the state is not IDLE.

Function
REQ-015 FSM states: IDLE and EXEC only.
REQ-016 IDLE, req!=0 at an edge: select winner w, load alu_a/alu_b/alu_aluc from w's slice, gnt[w]<=1, cnt<=LAT, go to EXEC.
REQ-017 IDLE, req==0: gnt<=0, ALU output registers hold.
REQ-018 Arbitration: only one requester -> it wins; both -> the requester that is not last_w wins; last_w<=w on every grant.
REQ-019 EXEC, cnt!=1: cnt<=cnt-1, gnt<=0, done<=0.
REQ-020 EXEC, cnt==1: res<=alu_s, res_z<=alu_z, done[w]<=1, go to IDLE.
REQ-021 Latency: done asserts LAT edges after the grant edge; a new grant is possible one edge after the done edge; throughput is one operation per LAT+1 cycles.
REQ-022 gnt and done are never both high in the same cycle when LAT>1; when LAT=1 they occupy adjacent cycles.
REQ-023 req is ignored during EXEC; a requester holding req through done is arbitrated again as a new request.
REQ-024 Operands are sampled only at the grant edge; later changes on a_in/b_in/aluc_in do not affect the operation in flight.
REQ-025 done and gnt are never multi-hot; done[w] always matches the requester granted for that operation.

Reset
REQ-026 reset high clears immediately: state=IDLE, cnt=0, gnt=0, done=0, alu_a=0, alu_b=0, alu_aluc=0, res=0, res_z=0, last_w=1 (requester 0 wins the first contention).
REQ-027 reset during EXEC abandons the operation; no done is produced for it.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins contention and last_w is unused; when undefined, the round-robin of REQ-018 applies.

Verification
REQ-029 LAT=1, req=01, aluc0=0000, a0=5, b0=7 -> gnt=01 after edge 1; done=01 after edge 2, res=12, res_z=0.
REQ-030 LAT=1, req=10, aluc1=0100, a1=9, b1=9 -> done=10, res=0, res_z=1.
REQ-031 Round-robin build, req=11 held constantly -> gnt sequence 01,10,01,10; with ALU_ARB_FIXED_PRIO_EN -> gnt always 01.
REQ-032 LAT=3, req0 with op 0101, a=0x00F0, b=0x0F00 -> done exactly 3 edges after the grant edge, res=0x0FF0, busy high for 3 cycles.
REQ-033 Assert reset one cycle after the grant edge with LAT=3 -> all outputs 0 immediately, no done pulse, busy=0, next req=01 is granted normally.
REQ-034 Change a0 from 5 to 100 one cycle after grant, LAT=2, op ADD, b0=1 -> res=6.
